// File: rtl/cpld_uart_ctrl.sv
// Byte-stream controller driving the CPLD UART strobes on the lane shared with base RAM data[7:0].
// Optional build macro CPLD_UART_LOOPBACK_EN loops every received byte back out as the next tx byte.
module cpld_uart_ctrl #(
  parameter int unsigned PULSE_CYC   = 2,
  parameter int unsigned RECOVER_CYC = 3
) (
  input  logic       clk_10M,
  input  logic       reset_of_clk10M,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       uart_rdn,
  output logic       uart_wrn,
  input  logic       uart_dataready,
  input  logic       uart_tbre,
  input  logic       uart_tsre,
  input  logic [7:0] bus_data_in,
  output logic [7:0] bus_data_out,
  output logic       bus_data_oe,
  output logic       bus_owned
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_LOW    = 3'd1;
  localparam logic [2:0] RD_REC    = 3'd2;
  localparam logic [2:0] WR_SETUP  = 3'd3;
  localparam logic [2:0] WR_LOW    = 3'd4;
  localparam logic [2:0] WR_HOLD   = 3'd5;
  localparam logic [2:0] WAIT_TBRE = 3'd6;
  localparam logic [2:0] WAIT_TSRE = 3'd7;

  localparam logic [3:0] PULSE_LAST   = 4'(PULSE_CYC - 1);
  localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYC);

  logic [2:0] state;
  logic [3:0] pulse_cnt;
  logic [3:0] rec_cnt;
  logic       dr_m, dr_s, tbre_m, tbre_s, tsre_m, tsre_s;
  logic       rd_go, capture, lb_take;
  logic [7:0] lb_data;
  logic       lb_pending;

  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      dr_m   <= 1'b0;
      dr_s   <= 1'b0;
      tbre_m <= 1'b0;
      tbre_s <= 1'b0;
      tsre_m <= 1'b0;
      tsre_s <= 1'b0;
    end else begin
      dr_m   <= uart_dataready;
      dr_s   <= dr_m;
      tbre_m <= uart_tbre;
      tbre_s <= tbre_m;
      tsre_m <= uart_tsre;
      tsre_s <= tsre_m;
    end
  end

  // A read needs the single-entry rx buffer (or loopback slot) free and the stale-dataready window over.
  assign rd_go   = dr_s && (rec_cnt == 4'd0) && !rx_valid && !lb_pending;
  assign capture = (state == RD_LOW) && (pulse_cnt == 4'd0);
  assign lb_take = (state == IDLE) && !rd_go && lb_pending;

`ifdef CPLD_UART_LOOPBACK_EN
  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      lb_data    <= '0;
      lb_pending <= 1'b0;
    end else if (capture) begin
      lb_data    <= bus_data_in;
      lb_pending <= 1'b1;
    end else if (lb_take) begin
      lb_pending <= 1'b0;
    end
  end
`else
  assign lb_data    = '0;
  assign lb_pending = 1'b0;
`endif

  always_ff @(posedge clk_10M or posedge reset_of_clk10M) begin
    if (reset_of_clk10M) begin
      state        <= IDLE;
      pulse_cnt    <= '0;
      rec_cnt      <= '0;
      uart_rdn     <= 1'b1;
      uart_wrn     <= 1'b1;
      bus_data_oe  <= 1'b0;
      bus_data_out <= '0;
      bus_owned    <= 1'b0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      tx_ready     <= 1'b0;
    end else begin
      tx_ready <= 1'b0;
      if (rec_cnt != 4'd0) rec_cnt <= rec_cnt - 4'd1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (rd_go) begin
            state     <= RD_LOW;
            uart_rdn  <= 1'b0;
            bus_owned <= 1'b1;
            pulse_cnt <= PULSE_LAST;
          end else if (lb_take || tx_valid) begin
            state        <= WR_SETUP;
            bus_owned    <= 1'b1;
            bus_data_oe  <= 1'b1;
            bus_data_out <= lb_take ? lb_data : tx_data;
            tx_ready     <= !lb_take;
          end
        end
        RD_LOW: begin
          if (pulse_cnt == 4'd0) begin
            uart_rdn <= 1'b1;
            rec_cnt  <= RECOVER_LOAD;
            state    <= RD_REC;
`ifndef CPLD_UART_LOOPBACK_EN
            // Placed after the handshake clear so a same-edge capture wins.
            rx_data  <= bus_data_in;
            rx_valid <= 1'b1;
`endif
          end else begin
            pulse_cnt <= pulse_cnt - 4'd1;
          end
        end
        RD_REC: begin
          state     <= IDLE;
          bus_owned <= 1'b0;
        end
        WR_SETUP: begin
          uart_wrn  <= 1'b0;
          pulse_cnt <= PULSE_LAST;
          state     <= WR_LOW;
        end
        WR_LOW: begin
          if (pulse_cnt == 4'd0) begin
            uart_wrn <= 1'b1;
            state    <= WR_HOLD;
          end else begin
            pulse_cnt <= pulse_cnt - 4'd1;
          end
        end
        WR_HOLD: begin
          bus_data_oe <= 1'b0;
          state       <= WAIT_TBRE;
        end
        WAIT_TBRE: begin
          if (tbre_s) state <= WAIT_TSRE;
        end
        WAIT_TSRE: begin
          if (tsre_s) begin
            state     <= IDLE;
            bus_owned <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          bus_owned <= 1'b0;
        end
      endcase
    end
  end

endmodule
